// File: rtl/user_rq_arbiter.sv
// Packet-atomic round-robin arbiter that merges NUM_REQ AXI-S requester streams onto the PCIe RQ port.
// Optional per-requester completed-packet counters are enabled with `define USER_RQ_ARB_STATS_EN.
module user_rq_arbiter #(
    parameter int NUM_REQ             = 2,
    parameter int C_DATA_WIDTH        = 128,
    parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
    parameter int AXI4_RQ_TUSER_WIDTH = 62
) (
    input  logic                                   user_clk,
    input  logic                                   reset_n,
    input  logic [NUM_REQ*C_DATA_WIDTH-1:0]        req_tdata,
    input  logic [NUM_REQ*KEEP_WIDTH-1:0]          req_tkeep,
    input  logic [NUM_REQ*AXI4_RQ_TUSER_WIDTH-1:0] req_tuser,
    input  logic [NUM_REQ-1:0]                     req_tlast,
    input  logic [NUM_REQ-1:0]                     req_tvalid,
    output logic [NUM_REQ-1:0]                     req_tready,
    output logic [C_DATA_WIDTH-1:0]                s_axis_rq_tdata,
    output logic [KEEP_WIDTH-1:0]                  s_axis_rq_tkeep,
    output logic [AXI4_RQ_TUSER_WIDTH-1:0]         s_axis_rq_tuser,
    output logic                                   s_axis_rq_tlast,
    output logic                                   s_axis_rq_tvalid,
    input  logic                                   s_axis_rq_tready,
    output logic [1:0]                             grant_id,
    output logic                                   arb_busy
`ifdef USER_RQ_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]                  pkt_count
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                           r_state;
    state_t                           w_nextState;
    logic [1:0]                       r_rrPtr;
    logic [1:0]                       r_grant;
    logic [1:0]                       w_nextGrant;
    logic                             w_found;
    logic                             w_anyValid;
    logic                             w_ready;
    logic                             w_accept;

    logic [C_DATA_WIDTH-1:0]          w_selData;
    logic [KEEP_WIDTH-1:0]            w_selKeep;
    logic [AXI4_RQ_TUSER_WIDTH-1:0]   w_selUser;
    logic                             w_selLast;
    logic                             w_selValid;

    logic [C_DATA_WIDTH-1:0]          r_outData;
    logic [KEEP_WIDTH-1:0]            r_outKeep;
    logic [AXI4_RQ_TUSER_WIDTH-1:0]   r_outUser;
    logic                             r_outLast;
    logic                             r_outValid;

    // Rotating search starting just after the last served requester
    always_comb begin
        w_nextGrant = r_grant;
        w_found     = 1'b0;
        w_anyValid  = |req_tvalid;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && req_tvalid[(int'(r_rrPtr) + k) % NUM_REQ]) begin
                w_found     = 1'b1;
                w_nextGrant = 2'((int'(r_rrPtr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_selData  = '0;
        w_selKeep  = '0;
        w_selUser  = '0;
        w_selLast  = 1'b0;
        w_selValid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == 2'(i)) begin
                w_selData  = req_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
                w_selKeep  = req_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                w_selUser  = req_tuser[i*AXI4_RQ_TUSER_WIDTH +: AXI4_RQ_TUSER_WIDTH];
                w_selLast  = req_tlast[i];
                w_selValid = req_tvalid[i];
            end
        end
    end

    assign w_ready  = ~r_outValid | s_axis_rq_tready;
    assign w_accept = (r_state == BUSY) && w_selValid && w_ready;

    always_comb begin
        w_nextState = r_state;
        req_tready  = '0;
        case (r_state)
            IDLE: begin
                if (w_anyValid && w_found) begin
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (r_grant == 2'(i)) begin
                        req_tready[i] = w_ready;
                    end
                end
                if (w_accept && w_selLast) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // The output register holds its fields while stalled; only tvalid drops once drained
    always_ff @(posedge user_clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_rrPtr    <= 2'(NUM_REQ - 1);
            r_grant    <= 2'd0;
            r_outData  <= '0;
            r_outKeep  <= '0;
            r_outUser  <= '0;
            r_outLast  <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && w_anyValid && w_found) begin
                r_grant <= w_nextGrant;
            end
            if (w_accept && w_selLast) begin
                r_rrPtr <= r_grant;
            end
            if (w_accept) begin
                r_outData  <= w_selData;
                r_outKeep  <= w_selKeep;
                r_outUser  <= w_selUser;
                r_outLast  <= w_selLast;
                r_outValid <= 1'b1;
            end else if (s_axis_rq_tready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign s_axis_rq_tdata  = r_outData;
    assign s_axis_rq_tkeep  = r_outKeep;
    assign s_axis_rq_tuser  = r_outUser;
    assign s_axis_rq_tlast  = r_outLast;
    assign s_axis_rq_tvalid = r_outValid;
    assign grant_id         = r_grant;
    assign arb_busy         = (r_state == BUSY);

`ifdef USER_RQ_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] r_pktCount;

    always_ff @(posedge user_clk) begin
        if (!reset_n) begin
            r_pktCount <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_accept && w_selLast && r_grant == 2'(i)) begin
                    r_pktCount[i] <= r_pktCount[i] + 16'd1;
                end
            end
        end
    end

    assign pkt_count = r_pktCount;
`endif

endmodule
